// File: rtl/river_pkg.sv
// Shared types and constants for the river-crossing game controller.
// Position vectors are packed as {F, C, G, W}; 0 = start bank, 1 = far bank.
package river_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WIN  = 2'd1,
    LOSE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_ALONE   = 2'd0;
  localparam logic [1:0] SEL_CABBAGE = 2'd1;
  localparam logic [1:0] SEL_GOAT    = 2'd2;
  localparam logic [1:0] SEL_WOLF    = 2'd3;

  localparam logic [3:0] WIN_POS = 4'b1111;

  // Bits of {F,C,G,W} that cross the river for a given passenger select.
  // The farmer always crosses; the selected item rides with him.
  function automatic logic [3:0] cross_mask(input logic [1:0] sel);
    logic [3:0] m;
    m = 4'b1000;
    case (sel)
      SEL_CABBAGE: m = 4'b1100;
      SEL_GOAT:    m = 4'b1010;
      SEL_WOLF:    m = 4'b1001;
      default:     m = 4'b1000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/crossing_alarm.sv
// Combinational safety alarm: raised when the goat is left without the
// farmer on a bank shared with the cabbage or the wolf.
module crossing_alarm (
  input  logic f_i,
  input  logic c_i,
  input  logic g_i,
  input  logic w_i,
  output logic a_o
);

  // Goat unattended and sharing a bank with something it eats or that eats it.
  assign a_o = (f_i != g_i) & ((g_i == c_i) | (g_i == w_i));

endmodule

// File: rtl/river_crossing_ctrl.sv
// River-crossing game controller: owns the F/C/G/W bank bits, validates and
// applies moves, counts accepted moves and tracks PLAY/WIN/LOSE.
// Optional feature macro: RIVER_UNDO_EN adds an 'undo' input backed by a
// one-level history of positions and state.
//
// Handshake: move_valid is a single-cycle strobe with no ready; every cycle
// it is high is one request, acted on at the next rising edge. restart and
// undo are level-sampled commands with the same one-edge latency.
module river_crossing_ctrl
  import river_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             move_valid,
  input  logic [1:0]       move_sel,
  input  logic             restart,
`ifdef RIVER_UNDO_EN
  input  logic             undo,
`endif
  output logic             F,
  output logic             C,
  output logic             G,
  output logic             W,
  output logic             A,
  output logic             win,
  output logic             lose,
  output logic             illegal,
  output logic [CNT_W-1:0] move_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  logic [3:0]       pos_q;      // {F,C,G,W}
  logic [CNT_W-1:0] cnt_q;
  logic             illegal_q;

  logic [3:0]       mask_d;
  logic             legal_d;
  logic [3:0]       pos_d;
  logic [CNT_W-1:0] cnt_d;
  logic             alarm_nxt;
  state_t           state_d;

`ifdef RIVER_UNDO_EN
  logic [3:0]       hist_pos_q;
  state_t           hist_state_q;
  logic             hist_vld_q;
  logic             undo_ok;
`endif

  // Candidate move: positions, count and resulting game state if accepted.
  always_comb begin
    mask_d  = cross_mask(move_sel);
    // The passenger (if any) must be on the farmer's bank.
    legal_d = (move_sel == SEL_ALONE) ||
              (((pos_q & mask_d & 4'b0111) != 4'b0000) == pos_q[3]);
    pos_d   = pos_q ^ mask_d;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    if (pos_d == WIN_POS)
      state_d = WIN;
    else if (alarm_nxt)
      state_d = LOSE;
    else
      state_d = PLAY;
  end

  // Alarm on the candidate positions, used for the transition decision.
  crossing_alarm u_alarm_nxt (
    .f_i(pos_d[3]),
    .c_i(pos_d[2]),
    .g_i(pos_d[1]),
    .w_i(pos_d[0]),
    .a_o(alarm_nxt)
  );

  // Alarm on the registered positions, driven straight to the A output.
  crossing_alarm u_alarm_cur (
    .f_i(pos_q[3]),
    .c_i(pos_q[2]),
    .g_i(pos_q[1]),
    .w_i(pos_q[0]),
    .a_o(A)
  );

`ifdef RIVER_UNDO_EN
  assign undo_ok = undo && hist_vld_q && (state_q != WIN);
`endif

  // Game FSM: positions, move counter, illegal pulse and optional history.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q   <= PLAY;
      pos_q     <= 4'b0000;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
`ifdef RIVER_UNDO_EN
      hist_vld_q   <= 1'b0;
      hist_pos_q   <= 4'b0000;
      hist_state_q <= PLAY;
`endif
    end
`ifdef RIVER_UNDO_EN
    else if (undo_ok) begin
      state_q    <= hist_state_q;
      pos_q      <= hist_pos_q;
      cnt_q      <= (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      illegal_q  <= 1'b0;
      hist_vld_q <= 1'b0;
    end
`endif
    else begin
      illegal_q <= 1'b0;
      case (state_q)
        PLAY: begin
          if (move_valid) begin
            if (legal_d) begin
              pos_q   <= pos_d;
              cnt_q   <= cnt_d;
              state_q <= state_d;
`ifdef RIVER_UNDO_EN
              hist_pos_q   <= pos_q;
              hist_state_q <= state_q;
              hist_vld_q   <= 1'b1;
`endif
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        // WIN and LOSE are terminal until restart (or undo from LOSE).
        default: ;
      endcase
    end
  end

  assign F         = pos_q[3];
  assign C         = pos_q[2];
  assign G         = pos_q[1];
  assign W         = pos_q[0];
  assign win       = (state_q == WIN);
  assign lose      = (state_q == LOSE);
  assign illegal   = illegal_q;
  assign move_cnt  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Directed, table-driven bench for river_crossing_ctrl plus hand-written
// sequences for reset mid-game, counter saturation and undo.
module tb_river_crossing_ctrl;

  localparam int CNT_W = 4;

  localparam logic [1:0] S_PLAY = 2'd0;
  localparam logic [1:0] S_WIN  = 2'd1;
  localparam logic [1:0] S_LOSE = 2'd2;

  localparam logic [1:0] ALONE   = 2'd0;
  localparam logic [1:0] CABBAGE = 2'd1;
  localparam logic [1:0] GOAT    = 2'd2;
  localparam logic [1:0] WOLF    = 2'd3;

  logic             clk;
  logic             reset;
  logic             move_valid;
  logic [1:0]       move_sel;
  logic             restart;
  logic             undo;
  logic             f_o, c_o, g_o, w_o, a_o;
  logic             win, lose, illegal;
  logic [CNT_W-1:0] move_cnt;
  logic [1:0]       dbg_state;

  int checks;
  int failures;

  typedef struct {
    logic       rs;
    logic       mv;
    logic [1:0] sel;
    logic [3:0] pos;
    logic       a;
    logic       w;
    logic       l;
    logic       il;
    logic [3:0] cnt;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  river_crossing_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .move_valid(move_valid),
    .move_sel  (move_sel),
    .restart   (restart),
`ifdef RIVER_UNDO_EN
    .undo      (undo),
`endif
    .F         (f_o),
    .C         (c_o),
    .G         (g_o),
    .W         (w_o),
    .A         (a_o),
    .win       (win),
    .lose      (lose),
    .illegal   (illegal),
    .move_cnt  (move_cnt),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] pos, input logic a,
                           input logic w, input logic l, input logic il,
                           input logic [3:0] cnt, input logic [1:0] st);
    check({tag, ".fcgw"},    {4'b0, f_o, c_o, g_o, w_o}, {4'b0, pos});
    check({tag, ".alarm"},   {7'b0, a_o},     {7'b0, a});
    check({tag, ".win"},     {7'b0, win},     {7'b0, w});
    check({tag, ".lose"},    {7'b0, lose},    {7'b0, l});
    check({tag, ".illegal"}, {7'b0, illegal}, {7'b0, il});
    check({tag, ".cnt"},     {4'b0, move_cnt}, {4'b0, cnt});
    check({tag, ".state"},   {6'b0, dbg_state}, {6'b0, st});
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic rs, input logic mv,
                      input logic [1:0] sel, input logic ud);
    reset      = rst;
    restart    = rs;
    move_valid = mv;
    move_sel   = sel;
    undo       = ud;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    restart    = 1'b0;
    move_valid = 1'b0;
    undo       = 1'b0;
  endtask

  task automatic add_vec(input logic rs, input logic mv, input logic [1:0] sel,
                         input logic [3:0] pos, input logic a, input logic w,
                         input logic l, input logic il, input logic [3:0] cnt,
                         input logic [1:0] st);
    vec_t v;
    v.rs = rs; v.mv = mv; v.sel = sel; v.pos = pos; v.a = a;
    v.w = w; v.l = l; v.il = il; v.cnt = cnt; v.st = st;
    vecs.push_back(v);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    restart    = 1'b0;
    move_valid = 1'b0;
    move_sel   = 2'd0;
    undo       = 1'b0;

    //      rs  mv  sel      FCGW     A  win lose ill cnt  state
    // Solution sequence
    add_vec(0, 1, GOAT,    4'b1010, 0, 0, 0, 0, 4'd1, S_PLAY);
    add_vec(0, 1, ALONE,   4'b0010, 0, 0, 0, 0, 4'd2, S_PLAY);
    add_vec(0, 1, WOLF,    4'b1011, 0, 0, 0, 0, 4'd3, S_PLAY);
    add_vec(0, 1, GOAT,    4'b0001, 0, 0, 0, 0, 4'd4, S_PLAY);
    add_vec(0, 1, CABBAGE, 4'b1101, 0, 0, 0, 0, 4'd5, S_PLAY);
    add_vec(0, 1, ALONE,   4'b0101, 0, 0, 0, 0, 4'd6, S_PLAY);
    add_vec(0, 1, GOAT,    4'b1111, 0, 1, 0, 0, 4'd7, S_WIN);
    add_vec(0, 1, GOAT,    4'b1111, 0, 1, 0, 0, 4'd7, S_WIN);
    add_vec(0, 1, ALONE,   4'b1111, 0, 1, 0, 0, 4'd7, S_WIN);
    // Restart from WIN, then wolf first -> LOSE; later move ignored
    add_vec(1, 0, ALONE,   4'b0000, 0, 0, 0, 0, 4'd0, S_PLAY);
    add_vec(0, 1, WOLF,    4'b1001, 1, 0, 1, 0, 4'd1, S_LOSE);
    add_vec(0, 1, GOAT,    4'b1001, 1, 0, 1, 0, 4'd1, S_LOSE);
    // Restart with simultaneous move: move not applied
    add_vec(1, 1, GOAT,    4'b0000, 0, 0, 0, 0, 4'd0, S_PLAY);
    // Illegal cabbage after goat crossing, pulse lasts one cycle
    add_vec(0, 1, GOAT,    4'b1010, 0, 0, 0, 0, 4'd1, S_PLAY);
    add_vec(0, 1, CABBAGE, 4'b1010, 0, 0, 0, 1, 4'd1, S_PLAY);
    add_vec(0, 0, ALONE,   4'b1010, 0, 0, 0, 0, 4'd1, S_PLAY);
    // Back-to-back strobes: illegal twice, then legal moves
    add_vec(0, 1, ALONE,   4'b0010, 0, 0, 0, 0, 4'd2, S_PLAY);
    add_vec(0, 1, GOAT,    4'b0010, 0, 0, 0, 1, 4'd2, S_PLAY);
    add_vec(0, 1, GOAT,    4'b0010, 0, 0, 0, 1, 4'd2, S_PLAY);
    add_vec(0, 1, CABBAGE, 4'b1110, 0, 0, 0, 0, 4'd3, S_PLAY);
    // Farmer leaves goat with cabbage -> 0110 alarm
    add_vec(0, 1, ALONE,   4'b0110, 1, 0, 1, 0, 4'd4, S_LOSE);
    // Restart, then goat twice in a row (held strobe = two requests)
    add_vec(1, 0, ALONE,   4'b0000, 0, 0, 0, 0, 4'd0, S_PLAY);
    add_vec(0, 1, GOAT,    4'b1010, 0, 0, 0, 0, 4'd1, S_PLAY);
    add_vec(0, 1, GOAT,    4'b0000, 0, 0, 0, 0, 4'd2, S_PLAY);
    // Farmer alone from start -> 1000 alarm
    add_vec(0, 1, ALONE,   4'b1000, 1, 0, 1, 0, 4'd3, S_LOSE);

    // Reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset", 4'b0000, 0, 0, 0, 0, 4'd0, S_PLAY);

    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b0, vecs[i].rs, vecs[i].mv, vecs[i].sel, 1'b0);
      check_all($sformatf("vec%0d", i), vecs[i].pos, vecs[i].a, vecs[i].w,
                vecs[i].l, vecs[i].il, vecs[i].cnt, vecs[i].st);
    end

    // Reset mid-game wins over restart and move in the same cycle
    step(1'b0, 1'b1, 1'b0, ALONE, 1'b0);
    step(1'b0, 1'b0, 1'b1, GOAT, 1'b0);
    check_all("pre_rst", 4'b1010, 0, 0, 0, 0, 4'd1, S_PLAY);
    step(1'b1, 1'b1, 1'b1, ALONE, 1'b0);
    check_all("mid_rst", 4'b0000, 0, 0, 0, 0, 4'd0, S_PLAY);

    // Counter saturation: goat back and forth 17 times
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 1'b0, 1'b1, GOAT, 1'b0);
      check_all($sformatf("sat%0d", i), (i % 2 == 1) ? 4'b1010 : 4'b0000,
                0, 0, 0, 0, (i > 15) ? 4'd15 : 4'(i), S_PLAY);
    end

`ifdef RIVER_UNDO_EN
    // Undo out of LOSE, second undo has no history
    step(1'b0, 1'b1, 1'b0, ALONE, 1'b0);
    step(1'b0, 1'b0, 1'b1, WOLF, 1'b0);
    check_all("undo_lose", 4'b1001, 1, 0, 1, 0, 4'd1, S_LOSE);
    step(1'b0, 1'b0, 1'b0, ALONE, 1'b1);
    check_all("undo1", 4'b0000, 0, 0, 0, 0, 4'd0, S_PLAY);
    step(1'b0, 1'b0, 1'b0, ALONE, 1'b1);
    check_all("undo2", 4'b0000, 0, 0, 0, 0, 4'd0, S_PLAY);
    // Undo beats a simultaneous move
    step(1'b0, 1'b0, 1'b1, GOAT, 1'b0);
    step(1'b0, 1'b0, 1'b1, ALONE, 1'b1);
    check_all("undo_prio", 4'b0000, 0, 0, 0, 0, 4'd0, S_PLAY);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/river_crossing_ctrl.md
Name: river_crossing_ctrl

Overview:
- Sequential game controller for the farmer/cabbage/goat/wolf river crossing.
- It is the producer side of the safety-alarm interface: it owns and updates the four bank-position bits (F,C,G,W; 0 = start bank, 1 = far bank).
- It evaluates the alarm condition on its own registered state and tracks PLAY/WIN/LOSE.
- Sits between board switch/button inputs and the LED/7-segment status display.

Parameters:
- CNT_W, 4: width of the move counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- move_valid  in  1  one-cycle move request strobe.
- move_sel  in  2  passenger select: 0 = farmer alone, 1 = cabbage, 2 = goat, 3 = wolf.
- restart  in  1  synchronous return to start position from any state.
- F  out  1  farmer bank (registered).
- C  out  1  cabbage bank (registered).
- G  out  1  goat bank (registered).
- W  out  1  wolf bank (registered).
- A  out  1  alarm, combinational from registered F,C,G,W.
- win  out  1  high while in WIN.
- lose  out  1  high while in LOSE.
- illegal  out  1  one-cycle pulse when a move is rejected.
- move_cnt  out  CNT_W  count of accepted moves.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Reset values: F=C=G=W=0, state=PLAY, move_cnt=0, illegal=0, win=0, lose=0, A=0.
- Alarm: A = (F!=G) & ((G==C) | (G==W)).
  - Equivalent: A=1 exactly for FCGW in {0011, 0110, 0111, 1000, 1001, 1100}.
- States: PLAY, WIN, LOSE.
- PLAY, move_valid=1:
  - Legal if move_sel=0, or the selected item's bank equals F.
  - Legal move: on the next edge, F toggles; the selected item also toggles (for move_sel≠0); move_cnt increments, saturating.
  - Illegal move: F,C,G,W and move_cnt are unchanged; illegal=1 for exactly the following cycle.
- State transition: evaluated on the next-state positions, so it occurs on the same edge as the position update (latency 1 cycle from the strobe):
  - next FCGW = 1111 -> WIN.
  - else next alarm = 1 -> LOSE.
  - else stay in PLAY.
- WIN/LOSE: move_valid ignored; no illegal pulse; positions and move_cnt hold.
- restart=1 (any state): next edge performs the reset values. restart has priority over move_valid in the same cycle.
- reset has priority over restart and move.
- Reset asserted mid-game: all state returns to reset values on that edge; no partial move is retained.
- move_valid held high over several cycles: each cycle is treated as a separate request.
- move_sel values are all defined, so no out-of-range case exists.

Optional Feature:
- Macro: RIVER_UNDO_EN.
- With the macro defined:
  - Adds input undo (1 bit).
  - A one-level history register captures FCGW and state before each accepted move.
  - undo=1 in PLAY or LOSE with valid history: restore FCGW and state, decrement move_cnt (not below 0), clear history valid.
  - undo is ignored in WIN or with no valid history.
  - Priority: reset > restart > undo > move.
  - restart and reset clear history valid.
- Without the macro: no undo port and no history register; behaviour exactly as above.

Decomposition:
- Package river_pkg holds:
  - state_t enum {PLAY, WIN, LOSE}.
  - Move-select constants SEL_ALONE=2'd0, SEL_CABBAGE=2'd1, SEL_GOAT=2'd2, SEL_WOLF=2'd3.
  - WIN_POS=4'b1111.
- One sub-module, crossing_alarm: pure combinational alarm from F,C,G,W. Instantiate it twice, once on current positions (drives A) and once on next positions (drives the transition).

Test Plan:
- Reset held 2 cycles -> FCGW=0000, A=0, win=0, lose=0, move_cnt=0.
- Solution sequence goat, alone, wolf, goat, cabbage, alone, goat:
  - Expected FCGW after each move: 1010, 0010, 1011, 0001, 1101, 0101, 1111.
  - A=0 throughout; win=1 with move_cnt=7 on the same edge as FCGW=1111; later moves are ignored.
- From reset, move wolf -> FCGW=1001, A=1, lose=1, move_cnt=1; a subsequent goat move is ignored.
- After goat move (1010), request cabbage -> illegal=1 for one cycle; FCGW stays 1010; move_cnt stays 1.
- In LOSE, assert restart together with move_valid=1 (sel goat) -> FCGW=0000, PLAY, move_cnt=0; the move is not applied.
- With RIVER_UNDO_EN defined: wolf move (LOSE) then undo -> FCGW=0000, PLAY, move_cnt=0; a second undo is ignored.
